// File: rtl/game_sync_tx.sv
// game_sync_tx: sends the local game status to the partner board as a
// 4-byte UART packet. The packet is A5, status, boss_hp, then an XOR checksum.
// A packet is sent on a status change, on a start press, or when the
// refresh interval expires. All outputs are registered, so they follow
// the FSM state one cycle later.
module game_sync_tx #(
  parameter int CLKS_PER_BIT   = 564,
  parameter int REFRESH_CYCLES = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic [1:0] game_state,
  input  logic [3:0] current_health,
  input  logic [6:0] boss_hp,
  output logic       tx,
  output logic       busy,
  output logic       pkt_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           pkt_sent_q, pkt_sent_d;
  logic           start_pending_q, start_pending_d;
  logic [RW-1:0]  refresh_q, refresh_d;
  logic [12:0]    last_sent_q, last_sent_d;
  logic [31:0]    shift_q, shift_d;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;

  logic [12:0]    status;
  logic           start_flag;
  logic           request;
  logic           bit_last;
  logic [7:0]     b1, b2, b3;

  assign status   = {game_state, current_health, boss_hp};
  assign bit_last = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  // Packet assembly from the live inputs; only used when a snapshot is taken.
  always_comb begin
    start_flag = start_pending_q | game_start;
    b1 = {game_state, start_flag, 1'b0, current_health};
    b2 = {1'b0, boss_hp};
    b3 = HEADER ^ b1 ^ b2;
    request = (status != last_sent_q) || start_pending_q || game_start ||
              (refresh_q == RW'(REFRESH_CYCLES - 1));
  end

  // Next-state logic: sequencing, shifting, and registered line outputs.
  always_comb begin
    state_d         = state_q;
    tx_d            = 1'b1;
    busy_d          = 1'b0;
    pkt_sent_d      = 1'b0;
    start_pending_d = start_pending_q | game_start;
    refresh_d       = refresh_q;
    last_sent_d     = last_sent_q;
    shift_d         = shift_q;
    clk_cnt_d       = clk_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    byte_cnt_d      = byte_cnt_q;

    case (state_q)
      ST_IDLE: begin
        refresh_d = refresh_q + RW'(1);
        if (request) begin
          // Byte 0 sits in the low bits so the line always shifts out bit 0.
          shift_d         = {b3, b2, b1, HEADER};
          last_sent_d     = status;
          start_pending_d = 1'b0;
          refresh_d       = '0;
          clk_cnt_d       = '0;
          byte_cnt_d      = '0;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (bit_last) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        tx_d   = shift_q[0];
        busy_d = 1'b1;
        if (bit_last) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[31:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        if (bit_last) begin
          clk_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ST_START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        pkt_sent_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any packet and invalidates last_sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      tx_q            <= 1'b1;
      busy_q          <= 1'b0;
      pkt_sent_q      <= 1'b0;
      start_pending_q <= 1'b0;
      refresh_q       <= '0;
      last_sent_q     <= '1;
      shift_q         <= '0;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      byte_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      tx_q            <= tx_d;
      busy_q          <= busy_d;
      pkt_sent_q      <= pkt_sent_d;
      start_pending_q <= start_pending_d;
      refresh_q       <= refresh_d;
      last_sent_q     <= last_sent_d;
      shift_q         <= shift_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign pkt_sent = pkt_sent_q;

endmodule

// File: tb/tb_game_sync_tx.sv
// Directed bench for game_sync_tx: decodes the UART line at every cycle
// and checks packet contents, bit timing, busy/pkt_sent and resend timing.
module tb_game_sync_tx;

  localparam int CPB = 4;
  localparam int REF = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_start = 1'b0;
  logic [1:0] game_state = 2'd0;
  logic [3:0] current_health = 4'd5;
  logic [6:0] boss_hp = 7'd100;
  logic       tx, busy, pkt_sent;

  int vectors = 0;
  int miscompares = 0;

  game_sync_tx #(.CLKS_PER_BIT(CPB), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_state(game_state),
    .current_health(current_health), .boss_hp(boss_hp),
    .tx(tx), .busy(busy), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  // Waits for a start bit, then samples 40 bits of CPB cycles each plus the
  // cycle after. pkt = {B0,B1,B2,B3}; waited = idle samples before the start
  // bit (-1 on timeout); tail = {tx,busy,pkt_sent} one cycle after the packet.
  task automatic rx_packet(input int max_wait, output logic [31:0] pkt,
                           output int waited, output int glitches,
                           output int frame_errs, output int busy_errs,
                           output int extra_pulses, output logic [2:0] tail);
    logic first;
    int   p;
    pkt = '0; waited = 0; glitches = 0; frame_errs = 0;
    busy_errs = 0; extra_pulses = 0; tail = 3'b000;
    first = 1'b0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) break;
      waited++;
      if (waited > max_wait) begin
        waited = -1;
        return;
      end
    end
    for (int bi = 0; bi < 40; bi++) begin
      for (int s = 0; s < CPB; s++) begin
        if (!(bi == 0 && s == 0)) @(negedge clk);
        if (s == 0) first = tx;
        else if (tx !== first) glitches++;
        if (busy !== 1'b1) busy_errs++;
        if (pkt_sent !== 1'b0) extra_pulses++;
      end
      p = bi % 10;
      if (p == 0 && first !== 1'b0) frame_errs++;
      else if (p == 9 && first !== 1'b1) frame_errs++;
      else if (p != 0 && p != 9) pkt[(3 - bi / 10) * 8 + p - 1] = first;
    end
    @(negedge clk);
    tail = {tx, busy, pkt_sent};
  endtask

  logic [31:0] pkt;
  logic [2:0]  tail;
  int waited, glitches, frame_errs, busy_errs, extra_pulses;

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx, busy, pkt_sent} !== 3'b100) begin
        miscompares++;
        $display("FAIL reset_outputs: got {tx,busy,pkt_sent}=%b expected 100", {tx, busy, pkt_sent});
      end
    end
  endtask

  task automatic test_first_packet();
    game_state = 2'd0; current_health = 4'd5; boss_hp = 7'd100;
    rst = 1'b0;
    rx_packet(50, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
    vectors++;
    if (waited !== 1) begin miscompares++; $display("FAIL first_latency: got %0d expected 1", waited); end
    vectors++;
    if (pkt !== 32'hA5_05_64_C4) begin miscompares++; $display("FAIL first_bytes: got %h expected a50564c4", pkt); end
    vectors++;
    if (busy_errs + extra_pulses !== 0) begin miscompares++; $display("FAIL first_busy: busy_errs=%0d extra_pulses=%0d expected 0", busy_errs, extra_pulses); end
    vectors++;
    if (tail !== 3'b101) begin miscompares++; $display("FAIL first_done: got %b expected 101", tail); end
    $display("test_first_packet: pkt=%h waited=%0d", pkt, waited);
  endtask

  task automatic test_start_midpacket();
    int w2;
    fork
      rx_packet(50, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
      begin
        game_start = 1'b1;
        @(negedge clk); game_start = 1'b0;
        repeat (60) @(negedge clk);
        game_start = 1'b1;
        @(negedge clk); game_start = 1'b0;
        game_state = 2'd1;
      end
    join
    vectors++;
    if (pkt !== 32'hA5_25_64_E4) begin miscompares++; $display("FAIL midpkt_first_bytes: got %h expected a52564e4", pkt); end
    vectors++;
    if (tail !== 3'b101) begin miscompares++; $display("FAIL midpkt_first_done: got %b expected 101", tail); end
    rx_packet(50, pkt, w2, glitches, frame_errs, busy_errs, extra_pulses, tail);
    vectors++;
    if (w2 !== 1) begin miscompares++; $display("FAIL midpkt_gap: got %0d idle samples after pulse expected 1", w2); end
    vectors++;
    if (pkt !== 32'hA5_65_64_A4) begin miscompares++; $display("FAIL midpkt_second_bytes: got %h expected a56564a4", pkt); end
    $display("test_start_midpacket: second pkt=%h gap=%0d", pkt, w2);
  endtask

  task automatic test_refresh();
    rx_packet(REF + 200, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
    vectors++;
    if (waited !== REF) begin miscompares++; $display("FAIL refresh_interval: got %0d expected %0d", waited, REF); end
    vectors++;
    if (pkt !== 32'hA5_45_64_84) begin miscompares++; $display("FAIL refresh_bytes: got %h expected a5456484", pkt); end
    $display("test_refresh: pkt=%h waited=%0d", pkt, waited);
  endtask

  task automatic test_simultaneous_change();
    int lows;
    repeat (5) @(negedge clk);
    boss_hp = 7'd0; game_state = 2'd2;
    rx_packet(50, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
    vectors++;
    if (waited !== 1) begin miscompares++; $display("FAIL change_latency: got %0d expected 1", waited); end
    vectors++;
    if (pkt !== 32'hA5_85_00_20) begin miscompares++; $display("FAIL change_bytes: got %h expected a5850020", pkt); end
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    vectors++;
    if (lows !== 0) begin miscompares++; $display("FAIL change_single_packet: got %0d active samples expected 0", lows); end
    $display("test_simultaneous_change: pkt=%h", pkt);
  endtask

  task automatic test_reset_mid_packet();
    int found;
    game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1; break; end
    end
    vectors++;
    if (found !== 1) begin miscompares++; $display("FAIL rstmid_start: got found=%0d expected 1", found); end
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({tx, busy} !== 2'b10) begin miscompares++; $display("FAIL rstmid_abort: got {tx,busy}=%b expected 10", {tx, busy}); end
    @(negedge clk);
    vectors++;
    if ({tx, busy, pkt_sent} !== 3'b100) begin miscompares++; $display("FAIL rstmid_hold: got %b expected 100", {tx, busy, pkt_sent}); end
    rst = 1'b0;
    rx_packet(50, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
    vectors++;
    if (waited !== 1) begin miscompares++; $display("FAIL rstmid_latency: got %0d expected 1", waited); end
    vectors++;
    if (pkt !== 32'hA5_85_00_20) begin miscompares++; $display("FAIL rstmid_bytes: got %h expected a5850020", pkt); end
    $display("test_reset_mid_packet: pkt=%h", pkt);
  endtask

  task automatic test_bit_timing();
    fork
      rx_packet(50, pkt, waited, glitches, frame_errs, busy_errs, extra_pulses, tail);
      begin
        repeat (3) @(negedge clk);
        game_start = 1'b1;
        @(negedge clk); game_start = 1'b0;
      end
    join
    vectors++;
    if (pkt !== 32'hA5_A5_00_00) begin miscompares++; $display("FAIL timing_bytes: got %h expected a5a50000", pkt); end
    vectors++;
    if (glitches !== 0) begin miscompares++; $display("FAIL timing_bit_width: got %0d unstable samples expected 0", glitches); end
    vectors++;
    if (frame_errs !== 0) begin miscompares++; $display("FAIL timing_framing: got %0d start/stop errors expected 0", frame_errs); end
    vectors++;
    if (busy_errs + extra_pulses !== 0) begin miscompares++; $display("FAIL timing_busy: busy_errs=%0d extra_pulses=%0d expected 0", busy_errs, extra_pulses); end
    vectors++;
    if (tail !== 3'b101) begin miscompares++; $display("FAIL timing_done: got %b expected 101", tail); end
    @(negedge clk);
    vectors++;
    if (pkt_sent !== 1'b0) begin miscompares++; $display("FAIL timing_pulse_width: got %b expected 0", pkt_sent); end
    $display("test_bit_timing: pkt=%h glitches=%0d frame_errs=%0d", pkt, glitches, frame_errs);
  endtask

  initial begin
    test_reset();
    test_first_packet();
    test_start_midpacket();
    test_refresh();
    test_simultaneous_change();
    test_reset_mid_packet();
    test_bit_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_sync_tx.md
Name: game_sync_tx

Overview:
UART packet transmitter that sends the local game status to the partner board in two-player mode. The partner board decodes each packet and drives its player2_game_start and mirrored state from it. The block sits beside the game state machine and consumes that block's inputs and outputs: game_state, current_health, boss_hp and the local game_start pulse. It transmits on any status change, on a start press, and on a periodic refresh.

Parameters:
CLKS_PER_BIT, 564, clock cycles per UART bit (65 MHz / 115200 baud); bench uses 4.
REFRESH_CYCLES, 6_500_000, idle cycles before an unchanged status is re-sent (100 ms at 65 MHz); bench uses 500.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
game_start  in  1  single-cycle local start pulse
game_state  in  2  0=MENU, 1=GAME, 2=END_SCREEN
current_health  in  4  local player health
boss_hp  in  7  boss hit points
tx  out  1  UART serial line, idle high
busy  out  1  high while a packet is in flight
pkt_sent  out  1  one-cycle pulse when a packet completes

Behaviour:
- Reset values: tx=1, busy=0, pkt_sent=0, FSM=IDLE, start_pending=0, refresh counter=0.
- Reset values (continued): last_sent snapshot = all ones, so state field is 3 (invalid). This forces a packet straight after reset.
- Packet format, 4 bytes, sent in order:
  - B0 = 0xA5.
  - B1 = {game_state[1:0], start_flag, 1'b0, current_health[3:0]}.
  - B2 = {1'b0, boss_hp[6:0]}.
  - B3 = B0^B1^B2.
- Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Bytes follow back to back with no gap. Packet length is 40*CLKS_PER_BIT cycles.
- start_pending: set by any game_start pulse in any state, including mid-packet; sticky.
  - Cleared in the cycle a packet snapshot is taken; start_flag = start_pending at that point.
  - A game_start in the same cycle as the snapshot is included in that packet.
- Send request, evaluated only in IDLE. Any of:
  - {game_state, current_health, boss_hp} differs from last_sent;
  - start_pending=1 or game_start=1;
  - refresh counter reached REFRESH_CYCLES-1.
- Refresh counter increments every IDLE cycle and clears at each snapshot.
- FSM states: IDLE -> START -> DATA -> STOP -> (next byte ? START : DONE) -> IDLE.
  - IDLE with request at edge N: snapshot the inputs into a shift register and last_sent.
  - At N+1: tx=0 and busy=1.
  - Inputs changing during a packet do not alter it. The change is detected in the next IDLE.
- DONE: lasts one cycle. tx=1, busy=0, pkt_sent=1.
  - Followed by at least one IDLE cycle, so consecutive packets are separated by ≥2 idle-high cycles.
- busy is high from the first start-bit cycle through the last stop-bit cycle inclusive.
- Reset mid-packet: at the next edge tx=1, busy=0, FSM=IDLE and the packet is abandoned.
  - The partner discards it on checksum or header failure.
  - After reset release, a new packet starts (last_sent is forced invalid).
- game_state=3 on the input is transmitted as-is; no filtering.

Test Plan:
Use CLKS_PER_BIT=4 and REFRESH_CYCLES=500 for all scenarios.
1. Release rst with state=0, health=5, hp=100 -> tx falls 1 cycle after release; bytes A5, 05, 64, C4; busy high for 160 cycles; one pkt_sent pulse.
2. Pulse game_start mid-packet, then set state=1 (health=5, hp=100) -> first packet unchanged. Second packet: A5, 65, 64, A4, starting ≥2 idle cycles after pkt_sent.
3. Hold inputs constant after a packet -> tx stays high with no packet for 500 IDLE cycles. Then the identical packet is re-sent with start_flag=0.
4. Change boss_hp 100→0 and state 1→2 on the same cycle while IDLE -> single packet A5, 85, 00, 20.
5. Assert rst during DATA of B1 -> tx=1 and busy=0 at the next edge. After release, a full fresh packet with correct checksum.
6. Decode every bit at mid-bit sample points -> every bit is exactly 4 cycles, and every stop bit is 1.
